// File: rtl/dense_stream_engine.sv
// Fully-connected layer engine. It streams a flattened feature map in and runs one
// multiply-accumulate per element against NO weights. It then streams out the NO
// requantised results and tracks their argmax for the classifier stage.
module dense_stream_engine #(
  parameter int unsigned NO    = 10,
  parameter int unsigned IC    = 16,
  parameter int unsigned IH    = 7,
  parameter int unsigned IW    = 7,
  parameter int unsigned DW    = 8,
  parameter int unsigned AW    = 32,
  parameter int unsigned SHIFT = 7,
  parameter int unsigned WA    = 11,
  localparam int unsigned XW   = (NO > 1) ? $clog2(NO) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  input  logic [DW-1:0]    in_data,
  output logic             in_ready,
  output logic             w_rd,
  output logic [WA-1:0]    w_addr,
  input  logic [NO*DW-1:0] w_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DW-1:0]    out_data,
  output logic [XW-1:0]    out_idx,
  output logic [XW-1:0]    argmax,
  output logic             argmax_valid,
  output logic             busy,
  output logic             done
);

  localparam int unsigned N = IC * IH * IW;

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StOut} state_e;

  state_e                state_q, state_d;
  logic [WA-1:0]         k_q;
  logic [XW-1:0]         idx_q;
  logic signed [DW-1:0]  in_reg_q;
  logic                  stage_vld_q;
  logic signed [AW-1:0]  acc_q [NO];
  logic signed [DW-1:0]  max_val_q;
  logic [XW-1:0]         max_idx_q;
  logic [XW-1:0]         argmax_q;
  logic                  argmax_valid_q;
  logic                  done_q;

  logic                  in_hs, out_hs, start_go, last_in, last_out, better;
  logic signed [2*DW-1:0] prod [NO];
  logic signed [AW-1:0]  acc_sel, acc_shr;
  logic signed [DW-1:0]  res;

  // Handshake and control decode.
  always_comb begin
    in_ready  = (state_q == StRun);
    out_valid = (state_q == StOut);
    in_hs     = in_valid & in_ready;
    out_hs    = out_valid & out_ready;
    start_go  = (state_q == StIdle) & start;
    last_in   = in_hs & (k_q == WA'(N - 1));
    last_out  = out_hs & (idx_q == XW'(NO - 1));
    w_rd      = in_hs;
    w_addr    = k_q;
    busy      = (state_q != StIdle);
    done      = done_q;
    argmax    = argmax_q;
    argmax_valid = argmax_valid_q;
    out_idx   = idx_q;
  end

  // Full-width signed products of the staged element with each neuron's weight.
  always_comb begin
    for (int n = 0; n < NO; n++) begin
      prod[n] = '0;
      prod[n] = in_reg_q * $signed(w_data[n*DW +: DW]);
    end
  end

  // Requantise the selected accumulator: arithmetic shift, then clamp to DW bits.
  always_comb begin
    acc_sel = acc_q[idx_q];
    acc_shr = acc_sel >>> SHIFT;
    // In range exactly when all bits above the result's sign bit match it.
    if ((&acc_shr[AW-1:DW-1]) || !(|acc_shr[AW-1:DW-1])) begin
      res = acc_shr[DW-1:0];
    end else if (acc_shr[AW-1]) begin
      res = {1'b1, {(DW-1){1'b0}}};
    end else begin
      res = {1'b0, {(DW-1){1'b1}}};
    end
    out_data = out_valid ? res : '0;
    // Index 0 always seeds the running max; later ties keep the lower index.
    better = (idx_q == '0) || (res > max_val_q);
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StRun;
      StRun:   if (last_in) state_d = StDrain;
      StDrain: state_d = StOut;
      StOut:   if (last_out) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  // Input staging and element counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      k_q         <= '0;
      in_reg_q    <= '0;
      stage_vld_q <= 1'b0;
    end else begin
      stage_vld_q <= in_hs;
      if (in_hs) in_reg_q <= in_data;
      if (start_go)   k_q <= '0;
      else if (in_hs) k_q <= k_q + WA'(1);
    end
  end

  // Accumulators: cleared on start, MAC one cycle after each input handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int n = 0; n < NO; n++) acc_q[n] <= '0;
    end else if (start_go) begin
      for (int n = 0; n < NO; n++) acc_q[n] <= '0;
    end else if (stage_vld_q) begin
      for (int n = 0; n < NO; n++) begin
        acc_q[n] <= acc_q[n] + {{(AW-2*DW){prod[n][2*DW-1]}}, prod[n]};
      end
    end
  end

  // Output index, running max, argmax and completion pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q          <= '0;
      max_val_q      <= '0;
      max_idx_q      <= '0;
      argmax_q       <= '0;
      argmax_valid_q <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      done_q <= last_out;
      if (start_go) begin
        idx_q          <= '0;
        max_val_q      <= '0;
        max_idx_q      <= '0;
        argmax_q       <= '0;
        argmax_valid_q <= 1'b0;
      end else if (out_hs) begin
        if (better) begin
          max_val_q <= res;
          max_idx_q <= idx_q;
        end
        if (last_out) begin
          idx_q          <= '0;
          argmax_q       <= better ? idx_q : max_idx_q;
          argmax_valid_q <= 1'b1;
        end else begin
          idx_q <= idx_q + XW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_dense_stream_engine.sv
// Directed bench for dense_stream_engine. Instance A (NO=4, two elements, SHIFT=0)
// covers basic MAC, saturation, backpressure, ties, ignored start and mid-run reset.
// Instance B (NO=2, one element, SHIFT=7) covers arithmetic-shift requantisation.
module tb_dense_stream_engine;

  logic clk, rst;

  // Instance A signals
  logic             a_start, a_in_valid, a_in_ready, a_w_rd, a_out_valid, a_out_ready;
  logic signed [7:0] a_in_data, a_out_data;
  logic [1:0]       a_w_addr, a_out_idx, a_argmax;
  logic [31:0]      a_w_data;
  logic             a_argmax_valid, a_busy, a_done;

  // Instance B signals
  logic             b_start, b_in_valid, b_in_ready, b_w_rd, b_out_valid, b_out_ready;
  logic signed [7:0] b_in_data, b_out_data;
  logic [0:0]       b_w_addr, b_out_idx, b_argmax;
  logic [15:0]      b_w_data;
  logic             b_argmax_valid, b_busy, b_done;

  logic [31:0] wmem_a [4];
  logic [15:0] wrow_b;
  int vin [2];
  int expv [4];
  int exp_arg;
  int n_checks = 0;
  int n_fail = 0;

  dense_stream_engine #(
    .NO(4), .IC(1), .IH(1), .IW(2), .DW(8), .AW(32), .SHIFT(0), .WA(2)
  ) u_dut_a (
    .clk(clk), .rst(rst), .start(a_start), .in_valid(a_in_valid), .in_data(a_in_data),
    .in_ready(a_in_ready), .w_rd(a_w_rd), .w_addr(a_w_addr), .w_data(a_w_data),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
    .out_idx(a_out_idx), .argmax(a_argmax), .argmax_valid(a_argmax_valid),
    .busy(a_busy), .done(a_done)
  );

  dense_stream_engine #(
    .NO(2), .IC(1), .IH(1), .IW(1), .DW(8), .AW(32), .SHIFT(7), .WA(1)
  ) u_dut_b (
    .clk(clk), .rst(rst), .start(b_start), .in_valid(b_in_valid), .in_data(b_in_data),
    .in_ready(b_in_ready), .w_rd(b_w_rd), .w_addr(b_w_addr), .w_data(b_w_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .out_idx(b_out_idx), .argmax(b_argmax), .argmax_valid(b_argmax_valid),
    .busy(b_busy), .done(b_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Weight memories: one-cycle read latency.
  always @(posedge clk) if (a_w_rd) a_w_data <= wmem_a[a_w_addr];
  always @(posedge clk) if (b_w_rd) b_w_data <= wrow_b;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] pack4(input int w0, input int w1, input int w2, input int w3);
    logic [7:0] b0, b1, b2, b3;
    b0 = 8'(w0); b1 = 8'(w1); b2 = 8'(w2); b3 = 8'(w3);
    return {b3, b2, b1, b0};
  endfunction

  task automatic setup_a(input int x0, input int x1, input logic [31:0] r0,
                         input logic [31:0] r1, input int e0, input int e1,
                         input int e2, input int e3, input int arg);
    vin[0] = x0; vin[1] = x1;
    wmem_a[0] = r0; wmem_a[1] = r1;
    expv[0] = e0; expv[1] = e1; expv[2] = e2; expv[3] = e3;
    exp_arg = arg;
  endtask

  // One complete inference on instance A; optional input gaps, output stalls and a
  // start pulse issued while results are being emitted.
  task automatic run_a(input string nm, input bit gaps, input bit stall, input bit start_in_out);
    logic [15:0] gpat;
    int e, n, cyc, hold, dcnt, hd, hi;
    bit sent;
    int got [4];
    gpat = 16'b1011_0010_0110_1001;
    e = 0; n = 0; cyc = 0; hold = 0; dcnt = 0; hd = 0; hi = 0; sent = 0;
    a_start = 1'b1;
    step();
    a_start = 1'b0;
    check({nm, "_busy_after_start"}, a_busy, 1);
    check({nm, "_ready_after_start"}, a_in_ready, 1);
    while (e < 2 && cyc < 200) begin
      a_in_valid = gaps ? gpat[cyc % 16] : 1'b1;
      a_in_data  = 8'(vin[e]);
      if (a_in_valid && a_in_ready) e++;
      step();
      cyc++;
    end
    a_in_valid = 1'b0;
    check({nm, "_in_count"}, e, 2);
    check({nm, "_drain_ready"}, a_in_ready, 0);
    check({nm, "_drain_outvalid"}, a_out_valid, 0);
    step();
    check({nm, "_first_outvalid"}, a_out_valid, 1);
    cyc = 0;
    while (n < 4 && cyc < 400) begin
      if (start_in_out && n == 1 && !sent) begin
        a_start = 1'b1;
        sent = 1;
      end else begin
        a_start = 1'b0;
      end
      if (a_done) dcnt++;
      if (a_out_valid) begin
        if (stall && hold < 5) begin
          a_out_ready = 1'b0;
          if (hold == 0) begin
            hd = a_out_data;
            hi = a_out_idx;
          end else begin
            check({nm, "_stall_data"}, a_out_data, hd);
            check({nm, "_stall_idx"}, a_out_idx, hi);
          end
          hold++;
        end else begin
          a_out_ready = 1'b1;
          check({nm, "_out_idx"}, a_out_idx, n);
          got[n] = a_out_data;
          n++;
          hold = 0;
        end
      end else begin
        a_out_ready = 1'b0;
      end
      step();
      cyc++;
    end
    a_out_ready = 1'b0;
    a_start = 1'b0;
    check({nm, "_out_count"}, n, 4);
    for (int i = 0; i < 4; i++) check({nm, "_result"}, got[i], expv[i]);
    if (a_done) dcnt++;
    check({nm, "_done_pulse"}, a_done, 1);
    check({nm, "_busy_at_done"}, a_busy, 0);
    check({nm, "_argmax_valid"}, a_argmax_valid, 1);
    check({nm, "_argmax"}, a_argmax, exp_arg);
    step();
    if (a_done) dcnt++;
    check({nm, "_done_count"}, dcnt, 1);
    check({nm, "_argmax_held"}, a_argmax_valid, 1);
    check({nm, "_idle_busy"}, a_busy, 0);
  endtask

  initial begin
    rst = 1'b1;
    a_start = 0; a_in_valid = 0; a_in_data = 0; a_out_ready = 0;
    b_start = 0; b_in_valid = 0; b_in_data = 0; b_out_ready = 0;
    a_w_data = '0; b_w_data = '0;
    repeat (3) step();
    check("rst_in_ready", a_in_ready, 0);
    check("rst_out_valid", a_out_valid, 0);
    check("rst_busy", a_busy, 0);
    check("rst_done", a_done, 0);
    check("rst_argmax_valid", a_argmax_valid, 0);
    check("rst_argmax", a_argmax, 0);
    check("rst_out_data", a_out_data, 0);
    check("rst_w_rd", a_w_rd, 0);
    check("rst_b_busy", b_busy, 0);
    rst = 1'b0;
    step();

    // 3*2+4*5=26, 3*(-1)+4*1=1
    setup_a(3, 4, pack4(2, -1, 0, 0), pack4(5, 1, 0, 0), 26, 1, 0, 0, 0);
    run_a("basic", 0, 0, 0);
    run_a("bp", 1, 1, 0);

    // 16129->127, -16256->-128, 127 exact, 128->127; all-127 tie keeps index 0
    setup_a(127, -128, pack4(127, 0, 1, 0), pack4(0, 127, 0, -1), 127, -128, 127, 127, 0);
    run_a("sat", 0, 0, 0);

    setup_a(1, 2, pack4(5, 9, 9, 2), pack4(0, 0, 0, 0), 5, 9, 9, 2, 1);
    run_a("tie", 0, 0, 1);

    // Abort mid-RUN, then a fresh inference must see only the new data.
    setup_a(3, 4, pack4(2, -1, 0, 0), pack4(5, 1, 0, 0), 26, 1, 0, 0, 0);
    a_start = 1'b1;
    step();
    a_start = 1'b0;
    a_in_valid = 1'b1;
    a_in_data = 8'sd3;
    step();
    a_in_data = 8'sd4;
    rst = 1'b1;
    step();
    a_in_valid = 1'b0;
    check("midrst_busy", a_busy, 0);
    check("midrst_in_ready", a_in_ready, 0);
    rst = 1'b0;
    step();
    check("midrst_out_valid", a_out_valid, 0);
    setup_a(1, 2, pack4(5, 9, 9, 2), pack4(0, 0, 0, 0), 5, 9, 9, 2, 1);
    run_a("after_rst", 0, 0, 0);

    // Instance B: 3*(-43)=-129 >>>7 = -2; 3*85=255 >>>7 = 1
    wrow_b = {8'(85), 8'(-43)};
    b_start = 1'b1;
    step();
    b_start = 1'b0;
    check("b_ready", b_in_ready, 1);
    b_in_valid = 1'b1;
    b_in_data = 8'sd3;
    step();
    b_in_valid = 1'b0;
    check("b_drain_ready", b_in_ready, 0);
    step();
    check("b_out_valid", b_out_valid, 1);
    b_out_ready = 1'b1;
    check("b_out0", b_out_data, -2);
    check("b_idx0", b_out_idx, 0);
    step();
    check("b_out1", b_out_data, 1);
    check("b_idx1", b_out_idx, 1);
    step();
    b_out_ready = 1'b0;
    check("b_done", b_done, 1);
    check("b_argmax", b_argmax, 1);
    check("b_argmax_valid", b_argmax_valid, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
